rv32m_div_unit: RTL

//  Iterative radix-2 restoring divider implementing RV32M DIV/DIVU/REM/REMU.
//  It is the inverse-operation companion to the single-cycle ALU: it sits beside the ALU in EX.
//  The pipeline holds the instruction in EX while busy=1.

---
 rtl/rv32m_div_unit_if.sv | 25 ++
 rtl/rv32m_div_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/rv32m_div_unit_if.sv
// Request/response bundle between the EX stage and the iterative divider.
// No latency of its own; pure wiring.
// The pipeline stalls on busy; the divider never stalls its consumer.
interface rv32m_div_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, dividend, divisor, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, dividend, divisor, flush,
        output busy, done, result
    );
endinterface

// File: rtl/rv32m_div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Latency: done XLEN+2 cycles after the start edge; divide-by-zero/overflow finish in 1.
// Backpressure: busy holds the issuing instruction in EX; start is ignored unless idle.
module rv32m_div_unit #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    rv32m_div_unit_if.slave     div_if
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] rem, quo, dmag, result_q;
    logic            op_rem, neg_quo, neg_rem;

    // Operand decode, only meaningful while idle
    logic            signed_op, a_neg, b_neg, div_zero, ovf, special, accept;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    assign signed_op = ~div_if.op[0];
    assign a_neg     = signed_op & div_if.dividend[XLEN-1];
    assign b_neg     = signed_op & div_if.divisor[XLEN-1];
    assign a_mag     = a_neg ? (~div_if.dividend + 1'b1) : div_if.dividend;
    assign b_mag     = b_neg ? (~div_if.divisor + 1'b1) : div_if.divisor;
    assign div_zero  = (div_if.divisor == '0);
    assign ovf       = signed_op && (div_if.dividend == {1'b1, {(XLEN-1){1'b0}}})
                                 && (div_if.divisor == '1);
    assign special   = div_zero | ovf;
    assign accept    = (state == IDLE) && div_if.start && !div_if.flush;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = div_if.op[1] ? div_if.dividend : '1;
        else
            special_res = div_if.op[1] ? '0 : div_if.dividend;
    end

    // Shifted partial remainder can reach XLEN+1 bits when the divisor has its MSB set
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    logic            take;
    logic [XLEN-1:0] rem_nxt, quo_nxt, fix_res;
    logic            last;

    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = {1'b0, shifted} - {2'b00, dmag};
    assign take    = ~diff[XLEN+1];
    assign rem_nxt = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_nxt = {quo[XLEN-2:0], take};
    assign last    = (count == CW'(XLEN-1));

    always_comb begin
        fix_res = '0;
        if (op_rem)
            fix_res = neg_rem ? (~rem + 1'b1) : rem;
        else
            fix_res = neg_quo ? (~quo + 1'b1) : quo;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : CALC;
            CALC: begin
                if (div_if.flush) state_nxt = IDLE;
                else if (last)    state_nxt = FIX;
            end
            FIX:  state_nxt = div_if.flush ? IDLE : DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            dmag     <= '0;
            result_q <= '0;
            op_rem   <= 1'b0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_rem  <= div_if.op[1];
                    neg_quo <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    rem     <= '0;
                    quo     <= a_mag;
                    dmag    <= b_mag;
                    count   <= '0;
                    if (special) result_q <= special_res;
                end
                CALC: if (!div_if.flush) begin
                    rem   <= rem_nxt;
                    quo   <= quo_nxt;
                    count <= count + CW'(1);
                end
                FIX: if (!div_if.flush) result_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign div_if.busy   = (state == CALC) || (state == FIX);
    assign div_if.done   = (state == DONE);
    assign div_if.result = result_q;
endmodule
